bconv_grp_acc: RTL and testbench

//  Ternary 3x3 convolution accumulator with PAR_OC parallel output channels.
//  - Accumulates IN_GRP input-channel groups into a row buffer of SIZE pixel partial sums.
//  - On the last group, applies optional ReLU and the per-layer scale.
//  - Serialises the PAR_OC results per pixel over a valid/ready stream.
//  - Sits between the window generator (i_tdata taps) and the next layer's line buffer.

---
 rtl/bconv_grp_acc_if.sv | 30 +++
 rtl/bconv_grp_acc.sv | 135 +++++++++++++
 tb/tb_bconv_grp_acc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bconv_grp_acc_if.sv
// bconv_grp_acc_if: window stream in, per-channel result stream out, plus weight/scale load.
interface bconv_grp_acc_if #(
  parameter int WIDTH_W = 18,
  parameter int PAR_OC  = 8,
  parameter int QUANT_W = 16,
  parameter int WIDTH_O = 27
);
  logic                         i_hsync;
  logic                         i_weight_vld;
  logic [WIDTH_W*PAR_OC-1:0]    i_weight;
  logic signed [QUANT_W-1:0]    i_weight_e;
  logic                         i_relu_en;
  logic                         i_valid;
  logic                         o_ready;
  logic [WIDTH_W-1:0]           i_tdata;
  logic                         o_valid;
  logic                         i_ready;
  logic signed [WIDTH_O-1:0]    o_tdata;
  logic [$clog2(PAR_OC)-1:0]    o_ch;
  logic                         o_last;
  logic                         o_sat;
  modport master (
    output i_hsync, i_weight_vld, i_weight, i_weight_e, i_relu_en, i_valid, i_tdata, i_ready,
    input  o_ready, o_valid, o_tdata, o_ch, o_last, o_sat
  );
  modport slave (
    input  i_hsync, i_weight_vld, i_weight, i_weight_e, i_relu_en, i_valid, i_tdata, i_ready,
    output o_ready, o_valid, o_tdata, o_ch, o_last, o_sat
  );
endinterface

// File: rtl/bconv_grp_acc.sv
// bconv_grp_acc: ternary 3x3 conv accumulator over IN_GRP input groups, PAR_OC channels,
// ReLU + scale on the last group, results serialised one channel per handshake.
module bconv_grp_acc #(
  parameter int WIDTH_D = 2,
  parameter int LEN     = 3,
  parameter int WIDTH_W = WIDTH_D*LEN*LEN,
  parameter int PAR_OC  = 8,
  parameter int IN_GRP  = 4,
  parameter int SIZE    = 56,
  parameter int WIDTH_C = 11,
  parameter int QUANT_W = 16,
  parameter int WIDTH_O = WIDTH_C+QUANT_W
) (
  input logic i_sclk,
  input logic i_rst_n,
  bconv_grp_acc_if.slave bus
);
  localparam int NT = LEN*LEN;
  localparam int PW = $clog2(SIZE);
  localparam int GW = IN_GRP > 1 ? $clog2(IN_GRP) : 1;
  localparam int CW = $clog2(PAR_OC);
  localparam int SW = WIDTH_C+5;
  localparam logic [PW-1:0] P_LAST = PW'(SIZE-1);
  localparam logic [GW-1:0] G_LAST = GW'(IN_GRP-1);
  localparam logic [GW-1:0] G_PEN = GW'(IN_GRP-2);
  localparam logic [CW-1:0] C_LAST = CW'(PAR_OC-1);
  localparam logic signed [SW-1:0] S_MAX = SW'(2**(WIDTH_C-1)-1);
  localparam logic signed [SW-1:0] S_MIN = SW'(-(2**(WIDTH_C-1)));
  typedef enum logic [1:0] {ACC, LAST_IN, WAIT, EMIT} state_t;
  localparam state_t S_INIT = IN_GRP > 1 ? ACC : LAST_IN;
  state_t state, state_n;
  logic run, accept, emit_last, sat;
  logic [PW-1:0] pix_cnt, s1_addr;
  logic [GW-1:0] grp_cnt;
  logic [CW-1:0] ch;
  logic [WIDTH_W*PAR_OC-1:0] w_shadow, w_active, w_src, w_use;
  logic signed [QUANT_W-1:0] scale;
  logic [PAR_OC*WIDTH_C-1:0] mem [SIZE];
  logic [PAR_OC*WIDTH_C-1:0] rd_q, wr_d;
  logic signed [1:0] s1_prod [PAR_OC][NT];
  logic s1_vld, s1_first, s1_last, s2_vld;
  logic signed [SW-1:0] sum_w [PAR_OC];
  logic signed [WIDTH_C-1:0] sat_v [PAR_OC];
  logic signed [WIDTH_C-1:0] s2_sum [PAR_OC];
  logic signed [WIDTH_C-1:0] rl [PAR_OC];
  logic signed [WIDTH_O-1:0] hold [PAR_OC];
  logic [PAR_OC-1:0] clamp;
  assign bus.o_ready = run && (state == ACC || state == LAST_IN);
  assign bus.o_valid = state == EMIT;
  assign bus.o_ch = ch;
  assign bus.o_sat = sat;
  assign bus.o_tdata = hold[ch];
  assign bus.o_last = bus.o_valid && emit_last && ch == C_LAST;
  assign accept = bus.i_valid && bus.o_ready;
  // the first beat of a group sees a weight load in the same cycle
  assign w_src = bus.i_weight_vld ? bus.i_weight : w_shadow;
  assign w_use = pix_cnt == '0 ? w_src : w_active;
  always_ff @(posedge i_sclk or negedge i_rst_n)
    if (!i_rst_n) state <= S_INIT;
    else state <= state_n;
  always_comb begin
    state_n = bus.i_hsync ? S_INIT :
              state == ACC ? (accept && pix_cnt == P_LAST && grp_cnt == G_PEN ? LAST_IN : ACC) :
              state == LAST_IN ? (accept ? WAIT : LAST_IN) :
              state == WAIT ? (s2_vld ? EMIT : WAIT) :
              (bus.i_ready && ch == C_LAST ? (emit_last ? S_INIT : LAST_IN) : EMIT);
  end
  always_comb begin
    clamp = '0;
    wr_d = '0;
    for (int k = 0; k < PAR_OC; k++) begin
      sum_w[k] = s1_first ? '0 : SW'(signed'(rd_q[k*WIDTH_C +: WIDTH_C]));
      for (int t = 0; t < NT; t++) sum_w[k] = sum_w[k] + SW'(s1_prod[k][t]);
      clamp[k] = sum_w[k] > S_MAX || sum_w[k] < S_MIN;
      sat_v[k] = sum_w[k] > S_MAX ? S_MAX[WIDTH_C-1:0] :
                 sum_w[k] < S_MIN ? S_MIN[WIDTH_C-1:0] : sum_w[k][WIDTH_C-1:0];
      wr_d[k*WIDTH_C +: WIDTH_C] = sat_v[k];
      rl[k] = bus.i_relu_en && s2_sum[k] < 0 ? '0 : s2_sum[k];
    end
  end
  always_ff @(posedge i_sclk) begin
    rd_q <= mem[pix_cnt];
    s1_addr <= pix_cnt;
    s1_first <= grp_cnt == '0;
    s1_last <= grp_cnt == G_LAST;
    s2_sum <= sat_v;
    if (s1_vld && !s1_last) mem[s1_addr] <= wr_d;
    // a tap code is nonzero iff its LSB is set; the MSBs carry the sign
    for (int k = 0; k < PAR_OC; k++)
      for (int t = 0; t < NT; t++)
        s1_prod[k][t] <= !(bus.i_tdata[t*WIDTH_D] && w_use[k*WIDTH_W+t*WIDTH_D]) ? 2'b00 :
                         (bus.i_tdata[t*WIDTH_D+1] ^ w_use[k*WIDTH_W+t*WIDTH_D+1]) ? 2'b11 : 2'b01;
  end
  always_ff @(posedge i_sclk or negedge i_rst_n)
    if (!i_rst_n) begin
      run <= 1'b0;
      pix_cnt <= '0;
      grp_cnt <= '0;
      ch <= '0;
      sat <= 1'b0;
      emit_last <= 1'b0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      w_shadow <= '0;
      w_active <= '0;
      scale <= '0;
      for (int k = 0; k < PAR_OC; k++) hold[k] <= '0;
    end else begin
      run <= 1'b1;
      if (bus.i_weight_vld) w_shadow <= bus.i_weight;
      if (accept && pix_cnt == '0) w_active <= w_src;
      if (accept && pix_cnt == '0 && grp_cnt == G_LAST) scale <= bus.i_weight_e;
      if (s2_vld)
        for (int k = 0; k < PAR_OC; k++) hold[k] <= WIDTH_O'(rl[k]) * WIDTH_O'(scale);
      if (bus.i_hsync) begin
        pix_cnt <= '0;
        grp_cnt <= '0;
        ch <= '0;
        sat <= 1'b0;
        emit_last <= 1'b0;
        s1_vld <= 1'b0;
        s2_vld <= 1'b0;
      end else begin
        s1_vld <= accept;
        s2_vld <= s1_vld && s1_last;
        if (accept) begin
          pix_cnt <= pix_cnt == P_LAST ? '0 : pix_cnt + 1'b1;
          if (pix_cnt == P_LAST) grp_cnt <= grp_cnt == G_LAST ? '0 : grp_cnt + 1'b1;
        end
        if (accept && state == LAST_IN) emit_last <= pix_cnt == P_LAST;
        if (s1_vld && |clamp) sat <= 1'b1;
        if (bus.o_valid && bus.i_ready) ch <= ch == C_LAST ? '0 : ch + 1'b1;
      end
    end
endmodule

// File: tb/tb_bconv_grp_acc.sv
// tb_bconv_grp_acc: directed rows against a wide-accumulator DUT and a narrow (saturating) twin.
module tb_bconv_grp_acc;
  localparam logic [17:0] T_P = 18'h15555;
  localparam logic [17:0] T_N = 18'h3FFFF;
  localparam logic [17:0] T_MIX = 18'h22155;
  localparam logic [35:0] W_P = 36'h5_5555_5555;
  localparam logic [35:0] W_N = 36'hF_FFFF_FFFF;
  localparam logic [35:0] W_MIX = {T_P, T_N};
  typedef struct {logic signed [26:0] d; logic ch; logic last;} wd_t;
  logic clk = 1'b0, rst_n = 1'b1, hs = 1'b0, wv = 1'b0, relu = 1'b1, tv = 1'b0, rdy = 1'b1;
  logic [35:0] wt = '0;
  logic [17:0] td = '0;
  int n_chk = 0, n_err = 0;
  wd_t qa[$];
  logic signed [20:0] qs[$];
  bconv_grp_acc_if #(.WIDTH_W(18), .PAR_OC(2), .QUANT_W(16), .WIDTH_O(27)) a ();
  bconv_grp_acc_if #(.WIDTH_W(18), .PAR_OC(2), .QUANT_W(16), .WIDTH_O(21)) s ();
  assign {a.i_hsync, a.i_weight_vld, a.i_weight, a.i_weight_e, a.i_relu_en, a.i_valid, a.i_tdata, a.i_ready} =
         {hs, wv, wt, 16'sd3, relu, tv, td, rdy};
  assign {s.i_hsync, s.i_weight_vld, s.i_weight, s.i_weight_e, s.i_relu_en, s.i_valid, s.i_tdata, s.i_ready} =
         {hs, wv, wt, 16'sd3, relu, tv, td, rdy};
  bconv_grp_acc #(.PAR_OC(2), .IN_GRP(2), .SIZE(4), .WIDTH_C(11)) u_dut (.i_sclk(clk), .i_rst_n(rst_n), .bus(a));
  bconv_grp_acc #(.PAR_OC(2), .IN_GRP(2), .SIZE(4), .WIDTH_C(5)) u_sat (.i_sclk(clk), .i_rst_n(rst_n), .bus(s));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (a.o_valid && a.i_ready) qa.push_back('{a.o_tdata, a.o_ch, a.o_last});
    if (s.o_valid && s.i_ready) qs.push_back(s.o_tdata);
  end
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_w(input logic [35:0] w);
    wt = w;
    wv = 1'b1;
    tick();
    wv = 1'b0;
  endtask
  task automatic push(input logic [17:0] d, input bit byp);
    int k = 0;
    td = d;
    tv = 1'b1;
    wv = byp;
    while (!a.o_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("ready_timeout", a.o_ready, 1);
    tick();
    tv = 1'b0;
    wv = 1'b0;
  endtask
  task automatic grp(input logic [17:0] d, input int n);
    for (int i = 0; i < n; i++) push(d, 1'b0);
  endtask
  task automatic do_row(input logic [35:0] w0, input logic [35:0] w1, input logic [17:0] d, input bit byp);
    if (byp) begin
      wt = w0;
      push(d, 1'b1);
      grp(d, 3);
    end else begin
      load_w(w0);
      grp(d, 4);
    end
    load_w(w1);
    grp(d, 4);
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!a.o_valid && k < 20) begin
      tick();
      k++;
    end
    chk("valid_timeout", a.o_valid, 1);
  endtask
  task automatic check_words(input string tag, input int e0, input int e1, input int s0, input int s1);
    int k = 0;
    while ((qa.size() < 8 || qs.size() < 8) && k < 200) begin
      tick();
      k++;
    end
    repeat (6) tick();
    chk({tag, "_count"}, qa.size(), 8);
    chk({tag, "_scount"}, qs.size(), 8);
    foreach (qa[i]) begin
      chk({tag, "_data"}, qa[i].d, i % 2 ? e1 : e0);
      chk({tag, "_ch"}, qa[i].ch, i % 2);
      chk({tag, "_last"}, qa[i].last, i == 7);
    end
    foreach (qs[i]) chk({tag, "_satdata"}, qs[i], i % 2 ? s1 : s0);
    qa.delete();
    qs.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: no summary after %0d checks", n_chk);
    $fatal(1);
  end
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_ready", a.o_ready, 0);
    chk("rst_valid", a.o_valid, 0);
    chk("rst_tdata", a.o_tdata, 0);
    chk("rst_last", a.o_last, 0);
    chk("rst_sat", a.o_sat, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ready_after_rst", a.o_ready, 1);
    do_row(W_P, W_P, T_P, 1'b0);
    check_words("t1", 54, 54, 45, 45);
    chk("t1_osat", a.o_sat, 0);
    chk("t4_osat", s.o_sat, 1);
    hs = 1'b1;
    tick();
    hs = 1'b0;
    chk("t4_osat_clr", s.o_sat, 0);
    do_row(W_N, W_N, T_P, 1'b0);
    check_words("t2_relu", 0, 0, 0, 0);
    relu = 1'b0;
    do_row(W_N, W_N, T_P, 1'b0);
    check_words("t2_neg", -54, -54, -48, -48);
    relu = 1'b1;
    load_w(W_P);
    grp(T_P, 4);
    rdy = 1'b0;
    push(T_P, 1'b0);
    wait_valid();
    repeat (5) begin
      tick();
      chk("t3_valid", a.o_valid, 1);
      chk("t3_tdata", a.o_tdata, 54);
      chk("t3_ch", a.o_ch, 0);
      chk("t3_ready", a.o_ready, 0);
    end
    rdy = 1'b1;
    grp(T_P, 3);
    check_words("t3", 54, 54, 45, 45);
    relu = 1'b0;
    do_row(W_P, W_P, T_MIX, 1'b0);
    check_words("t5", 30, 30, 30, 30);
    load_w(W_N);
    do_row(W_P, W_MIX, T_MIX, 1'b1);
    check_words("t5_reload", 0, 30, 0, 30);
    relu = 1'b1;
    rdy = 1'b0;
    load_w(W_P);
    grp(T_P, 4);
    push(T_P, 1'b0);
    wait_valid();
    chk("t6_sat_pre", s.o_sat, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", a.o_valid, 0);
    chk("t6_rst_tdata", a.o_tdata, 0);
    chk("t6_rst_ch", a.o_ch, 0);
    chk("t6_rst_ready", a.o_ready, 0);
    chk("t6_rst_sat", s.o_sat, 0);
    @(negedge clk) rst_n = 1'b1;
    rdy = 1'b1;
    tick();
    qa.delete();
    qs.delete();
    relu = 1'b0;
    load_w(W_N);
    grp(T_P, 4);
    push(T_P, 1'b0);
    push(T_P, 1'b0);
    hs = 1'b1;
    tick();
    hs = 1'b0;
    qa.delete();
    qs.delete();
    relu = 1'b1;
    do_row(W_P, W_P, T_P, 1'b0);
    check_words("t6_hsync", 54, 54, 45, 45);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
